// File: rtl/dpram_sync_clr.sv
// dpram_sync_clr: true dual-port RAM on a single clock.
// After reset it runs a self-clearing sweep, then accepts requests on ports A and B.
// The RAM flags same-address collisions and supports read-first or write-first own-port echo.
// Optional macro DPRAM_OUTREG_EN adds a second output register, which gives a read latency of 2.
module dpram_sync_clr #(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 8,
  parameter int                 DEPTH   = (1 << ADDR_W),
  parameter int                 RD_MODE = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              busy,
  output logic              collision
);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam bit                WR_FIRST = (RD_MODE != 0);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                busy_q;
  logic                coll_q;
  logic                coll_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                run;
  logic                a_ok, b_ok, same_addr;
  logic                a_acc, b_acc;
  logic                a_wr, b_wr;
  logic [DATA_W-1:0]   douta_d, doutb_d;
  logic [DATA_W-1:0]   dout_a_p1_q, dout_b_p1_q;

  // Request qualification: only in RUN and never during the reset cycle itself
  always_comb begin
    run       = (state_q == ST_RUN) && !rst;
    a_ok      = ({1'b0, addra} < DEPTH_L);
    b_ok      = ({1'b0, addrb} < DEPTH_L);
    same_addr = a_ok && b_ok && (addra == addrb);
    a_acc     = run && ena;
    b_acc     = run && enb;
    a_wr      = a_acc && wea && a_ok;
    // Port A wins a same-address write-write collision; B's write is dropped
    b_wr      = b_acc && web && b_ok && !(a_wr && same_addr);
    coll_d    = a_acc && b_acc && same_addr && (wea || web);
  end

  // Next output word per port: out-of-range reads 0, own-port write echoes old or new data
  always_comb begin
    douta_d = '0;
    doutb_d = '0;
    if (a_ok) begin
      if (wea && WR_FIRST) douta_d = dina;
      else                 douta_d = mem[addra];
    end
    if (b_ok) begin
      if (web && WR_FIRST) doutb_d = dinb;
      else                 doutb_d = mem[addrb];
    end
  end

  // Control FSM: clear sweep one word per cycle, then RUN until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      coll_q  <= 1'b0;
    end else begin
      coll_q <= coll_d;
      case (state_q)
        ST_CLEAR: begin
          if (ptr_q == LAST_PTR) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        ST_RUN: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage writes: sweep value while clearing, port writes while running
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      if (!rst) mem[ptr_q] <= CLR_VAL;
    end else begin
      if (b_wr) mem[addrb] <= dinb;
      if (a_wr) mem[addra] <= dina;
    end
  end

  // Stage p1: first output register, loaded only on an enabled access in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a_p1_q <= '0;
      dout_b_p1_q <= '0;
    end else begin
      if (a_acc) dout_a_p1_q <= douta_d;
      if (b_acc) dout_b_p1_q <= doutb_d;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic              vld_a_p1_q, vld_b_p1_q;
  logic [DATA_W-1:0] dout_a_p2_q, dout_b_p2_q;

  // Stage p2: second output register follows p1 only when p1 took new data, so idle ports hold
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a_p1_q  <= 1'b0;
      vld_b_p1_q  <= 1'b0;
      dout_a_p2_q <= '0;
      dout_b_p2_q <= '0;
    end else begin
      vld_a_p1_q <= a_acc;
      vld_b_p1_q <= b_acc;
      if (vld_a_p1_q) dout_a_p2_q <= dout_a_p1_q;
      if (vld_b_p1_q) dout_b_p2_q <= dout_b_p1_q;
    end
  end

  assign douta = dout_a_p2_q;
  assign doutb = dout_b_p2_q;
`else
  assign douta = dout_a_p1_q;
  assign doutb = dout_b_p1_q;
`endif

  assign busy      = busy_q;
  assign collision = coll_q;

endmodule
